// File: rtl/fft_bfly_feeder_if.sv
// rtl/fft_bfly_feeder_if.sv - Bus bundle between fft_bfly_feeder, its sample source/sink and the butterfly
// Signals (WIDTH-bit packed complex: upper half real, lower half imag):
//   in_valid/in_ready/in_data       time-domain sample stream into the feeder
//   bf_en/bf_a/bf_b/bf_t            butterfly issue (operands A, B, twiddle T)
//   bf_valid/bf_pos/bf_neg          butterfly results A+T*B / A-T*B, one cycle after issue
//   out_valid/out_ready/out_data    frequency-domain sample stream out of the feeder
//   busy                            feeder is not in its load phase
//   frame_cnt                       completed output frames (only with FFT_FEEDER_FRAME_CNT_EN)
// Modports: master = feeder side, slave = environment side.
interface fft_bfly_feeder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             bf_en;
    logic [WIDTH-1:0] bf_a;
    logic [WIDTH-1:0] bf_b;
    logic [WIDTH-1:0] bf_t;
    logic             bf_valid;
    logic [WIDTH-1:0] bf_pos;
    logic [WIDTH-1:0] bf_neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef FFT_FEEDER_FRAME_CNT_EN
    logic [7:0]       frame_cnt;
`endif

    modport master (
        input  in_valid, in_data, bf_valid, bf_pos, bf_neg, out_ready,
        output in_ready, bf_en, bf_a, bf_b, bf_t, out_valid, out_data, busy
`ifdef FFT_FEEDER_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output in_valid, in_data, bf_valid, bf_pos, bf_neg, out_ready,
        input  in_ready, bf_en, bf_a, bf_b, bf_t, out_valid, out_data, busy
`ifdef FFT_FEEDER_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/fft_bfly_feeder.sv
// rtl/fft_bfly_feeder.sv - 4-point radix-2 DIT FFT sequencer feeding an external butterfly unit
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    fft_bfly_feeder_if.master: sample input stream, butterfly issue/result, output stream, busy
// Parameters: WIDTH packed complex width, TW0/TW1 twiddles W4^0 / W4^1.
// Optional: FFT_FEEDER_FRAME_CNT_EN adds bus.frame_cnt, an 8-bit wrapping count of output frames.
module fft_bfly_feeder #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TW0   = 8'h70,
    parameter logic [WIDTH-1:0] TW1   = 8'h09
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_bfly_feeder_if.master bus
);
    typedef enum logic [2:0] {
        ST_LOAD, ST_S1_I0, ST_S1_I1, ST_S1_W, ST_S2_I0, ST_S2_I1, ST_S2_W, ST_OUT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_in_cnt;
    logic [1:0]       r_out_cnt;
    logic [WIDTH-1:0] r_mem [4];
    logic             r_in_ready;
    logic             r_bf_en;
    logic [WIDTH-1:0] r_bf_a;
    logic [WIDTH-1:0] r_bf_b;
    logic [WIDTH-1:0] r_bf_t;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_busy;
    logic [1:0]       r_op_a;
    logic [1:0]       r_op_b;
    logic             r_wb_pend;
    logic [1:0]       r_wb_a;
    logic [1:0]       r_wb_b;
`ifdef FFT_FEEDER_FRAME_CNT_EN
    logic [7:0]       r_frame_cnt;
`endif

    logic             w_accept;
    logic             w_out_fire;
    logic             w_wb_fire;
    logic [WIDTH-1:0] w_mem_wb [4];
    logic             w_iss_en;
    logic [1:0]       w_iss_a;
    logic [1:0]       w_iss_b;
    logic [WIDTH-1:0] w_iss_t;

    // r_in_ready is only ever high in LOAD, so it doubles as the state qualifier.
    assign w_accept   = r_in_ready & bus.in_valid;
    assign w_out_fire = r_out_valid & bus.out_ready;
    assign w_wb_fire  = r_wb_pend & bus.bf_valid;

    // Buffer contents as they will be after this edge's writeback. Operands and
    // output data are registered from this view so a result landing on the same
    // edge (e.g. mem2 at the S1_W -> S2_I0 edge) is forwarded, not read stale.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_mem_wb[i] = r_mem[i];
        end
        if (w_wb_fire) begin
            w_mem_wb[r_wb_a] = bus.bf_pos;
            w_mem_wb[r_wb_b] = bus.bf_neg;
        end
    end

    // Butterfly to issue in the state entered at this edge, decoded from the
    // state being left: LOAD->S1_I0, S1_I0->S1_I1, S1_W->S2_I0, S2_I0->S2_I1.
    always_comb begin
        w_iss_en = 1'b0;
        w_iss_a  = 2'd0;
        w_iss_b  = 2'd0;
        w_iss_t  = TW0;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && r_in_cnt == 2'd3) begin
                    w_iss_en = 1'b1;
                    w_iss_a  = 2'd0;
                    w_iss_b  = 2'd1;
                end
            end
            ST_S1_I0: begin
                w_iss_en = 1'b1;
                w_iss_a  = 2'd2;
                w_iss_b  = 2'd3;
            end
            ST_S1_W: begin
                w_iss_en = 1'b1;
                w_iss_a  = 2'd0;
                w_iss_b  = 2'd2;
            end
            ST_S2_I0: begin
                w_iss_en = 1'b1;
                w_iss_a  = 2'd1;
                w_iss_b  = 2'd3;
                w_iss_t  = TW1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_in_cnt    <= 2'd0;
            r_out_cnt   <= 2'd0;
            r_mem       <= '{default: '0};
            r_in_ready  <= 1'b1;
            r_bf_en     <= 1'b0;
            r_bf_a      <= '0;
            r_bf_b      <= '0;
            r_bf_t      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_op_a      <= 2'd0;
            r_op_b      <= 2'd0;
            r_wb_pend   <= 1'b0;
            r_wb_a      <= 2'd0;
            r_wb_b      <= 2'd0;
`ifdef FFT_FEEDER_FRAME_CNT_EN
            r_frame_cnt <= 8'd0;
`endif
        end else begin
            r_mem <= w_mem_wb;
            // Sample k lands at its bit-reversed address so both stages use in-place pairs.
            if (w_accept) begin
                r_mem[{r_in_cnt[0], r_in_cnt[1]}] <= bus.in_data;
            end

            // Writeback slot is the cycle right after an issue cycle.
            r_wb_pend <= r_bf_en;
            r_wb_a    <= r_op_a;
            r_wb_b    <= r_op_b;

            r_bf_en <= w_iss_en;
            r_bf_a  <= w_iss_en ? w_mem_wb[w_iss_a] : '0;
            r_bf_b  <= w_iss_en ? w_mem_wb[w_iss_b] : '0;
            r_bf_t  <= w_iss_en ? w_iss_t : '0;
            if (w_iss_en) begin
                r_op_a <= w_iss_a;
                r_op_b <= w_iss_b;
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_in_cnt <= r_in_cnt + 2'd1;
                        if (r_in_cnt == 2'd3) begin
                            r_state    <= ST_S1_I0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_S1_I0: r_state <= ST_S1_I1;
                ST_S1_I1: r_state <= ST_S1_W;
                ST_S1_W:  r_state <= ST_S2_I0;
                ST_S2_I0: r_state <= ST_S2_I1;
                ST_S2_I1: r_state <= ST_S2_W;
                ST_S2_W: begin
                    r_state     <= ST_OUT;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_mem_wb[0];
                end
                ST_OUT: begin
                    if (w_out_fire) begin
                        r_out_cnt <= r_out_cnt + 2'd1;
                        if (r_out_cnt == 2'd3) begin
                            r_state     <= ST_LOAD;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
`ifdef FFT_FEEDER_FRAME_CNT_EN
                            r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
                        end else begin
                            r_out_data <= w_mem_wb[r_out_cnt + 2'd1];
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.bf_en     = r_bf_en;
    assign bus.bf_a      = r_bf_a;
    assign bus.bf_b      = r_bf_b;
    assign bus.bf_t      = r_bf_t;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
`ifdef FFT_FEEDER_FRAME_CNT_EN
    assign bus.frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_fft_bfly_feeder.sv
// tb/tb_fft_bfly_feeder.sv - Self-checking bench for fft_bfly_feeder with a behavioural butterfly
module tb_fft_bfly_feeder;
    typedef logic [7:0] frame_t [4];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_bfly_feeder_if #(.WIDTH(8)) bus ();
    fft_bfly_feeder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_pass = 0;
    int n_total = 0;
    int tb_frames = 0;

    logic [3:0] drop_mask = 4'd0;
    int         op_idx = 0;
    logic       force_valid = 1'b0;

    frame_t      got;
    int          first_ov, accepts, inready_bad, bfz_bad, ov_drop, held_bad, stall_seen, nb, timeout;
    int          bf_n [8];
    logic [23:0] bf_op [8];
    logic [7:0]  held;

    // Complex multiply with twiddles scaled by 8 (7 ~ 1.0), 4-bit wrapping parts.
    function automatic void bfly(input logic [7:0] a, input logic [7:0] b, input logic [7:0] t,
                                 output logic [7:0] p, output logic [7:0] q);
        int ar, ai, br, bi, tr, ti, mr, mi;
        ar = int'($signed(a[7:4])); ai = int'($signed(a[3:0]));
        br = int'($signed(b[7:4])); bi = int'($signed(b[3:0]));
        tr = int'($signed(t[7:4])); ti = int'($signed(t[3:0]));
        mr = (tr * br - ti * bi) >>> 3;
        mi = (tr * bi + ti * br) >>> 3;
        p = {4'(ar + mr), 4'(ai + mi)};
        q = {4'(ar - mr), 4'(ai - mi)};
    endfunction

    // Reference 4-point DIT FFT: bit-reversed load, two in-place stages; dropped ops leave data untouched.
    function automatic void model(input frame_t x, input logic [3:0] drop, output frame_t y);
        int oa [4] = '{0, 2, 0, 1};
        int ob [4] = '{1, 3, 2, 3};
        logic [7:0] p, q;
        y[0] = x[0]; y[2] = x[1]; y[1] = x[2]; y[3] = x[3];
        for (int i = 0; i < 4; i++) begin
            if (!drop[i]) begin
                bfly(y[oa[i]], y[ob[i]], (i == 3) ? 8'h09 : 8'h70, p, q);
                y[oa[i]] = p;
                y[ob[i]] = q;
            end
        end
    endfunction

    function automatic void rand_frame(output frame_t x);
        for (int i = 0; i < 4; i++) x[i] = 8'($urandom);
    endfunction

    // Butterfly unit: answers each issue one cycle later unless that op is in drop_mask.
    initial begin
        logic       c_en, c_drop;
        logic [7:0] c_a, c_b, c_t, p, q;
        bus.bf_valid = 1'b0;
        bus.bf_pos   = 8'h00;
        bus.bf_neg   = 8'h00;
        forever begin
            @(negedge clk);
            c_en = bus.bf_en; c_a = bus.bf_a; c_b = bus.bf_b; c_t = bus.bf_t;
            c_drop = 1'b0;
            if (c_en) begin
                if (op_idx < 4) c_drop = drop_mask[op_idx];
                op_idx++;
            end
            @(posedge clk);
            #2;
            bfly(c_a, c_b, c_t, p, q);
            bus.bf_valid = (c_en && !c_drop) || force_valid;
            bus.bf_pos   = force_valid ? 8'h5A : p;
            bus.bf_neg   = force_valid ? 8'hA5 : q;
        end
    end

    // Loads one frame and observes the DUT until its 4th output handshake. Called at posedge+1.
    task automatic do_frame(input frame_t x, input int stall_at, input int stall_len, input bit hold, input bit spur);
        int j, n;
        bit done;
        first_ov = 0; accepts = 0; inready_bad = 0; bfz_bad = 0; ov_drop = 0;
        held_bad = 0; stall_seen = 0; nb = 0; timeout = 0; op_idx = 0;
        held = 8'h00;
        force_valid = spur;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1; bus.in_data = x[k]; bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.in_ready) accepts++;
            @(posedge clk);
            #1;
        end
        force_valid = 1'b0;
        j = 0; n = 0; done = 0;
        while (!done && n < 80) begin
            n++;
            bus.out_ready = !(j == stall_at && stall_seen < stall_len);
            if (hold) begin bus.in_valid = 1'b1; bus.in_data = 8'($urandom); end
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) accepts++;
            if (bus.in_ready !== 1'b0) inready_bad++;
            if (bus.bf_en) begin
                if (nb < 8) begin bf_n[nb] = n; bf_op[nb] = {bus.bf_a, bus.bf_b, bus.bf_t}; end
                nb++;
            end else if ({bus.bf_a, bus.bf_b, bus.bf_t} !== 24'h0) bfz_bad++;
            if (bus.out_valid) begin
                if (first_ov == 0) first_ov = n;
                if (bus.out_ready) begin
                    got[j] = bus.out_data;
                    j++;
                    if (j == 4) done = 1;
                end else begin
                    if (stall_seen == 0) held = bus.out_data;
                    else if (bus.out_data !== held) held_bad++;
                    stall_seen++;
                end
            end else if (first_ov != 0) ov_drop++;
            if (!done) begin @(posedge clk); #1; end
        end
        if (!done) timeout = 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        if (done) tb_frames++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy_in_reset got %b want 0", bus.busy); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.bf_en !== 1'b0) $display("FAIL reset_bf_en got %b want 0", bus.bf_en); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if ({bus.bf_a, bus.bf_b, bus.bf_t} !== 24'h0) $display("FAIL reset_bf_operands got %h want 0", {bus.bf_a, bus.bf_b, bus.bf_t}); else n_pass++;
`ifdef FFT_FEEDER_FRAME_CNT_EN
        n_total++; if (bus.frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt); else n_pass++;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_issue_order;
        frame_t x, y;
        logic [7:0] p0, q0, p1, q1;
        x = '{8'h11, 8'h22, 8'h33, 8'h44};
        model(x, 4'd0, y);
        bfly(8'h11, 8'h33, 8'h70, p0, q0);
        bfly(8'h22, 8'h44, 8'h70, p1, q1);
        do_frame(x, -1, 0, 0, 0);
        n_total++; if (timeout != 0) $display("FAIL issue_timeout got %0d want 0", timeout); else n_pass++;
        n_total++; if (nb != 4) $display("FAIL issue_bf_en_cycles got %0d want 4", nb); else n_pass++;
        n_total++; if (bf_n[0] != 1 || bf_n[1] != 2 || bf_n[2] != 4) $display("FAIL issue_cycles got %0d,%0d,%0d want 1,2,4", bf_n[0], bf_n[1], bf_n[2]); else n_pass++;
        n_total++; if (bf_op[0] !== 24'h113370) $display("FAIL issue_s1_op0 got %h want 113370", bf_op[0]); else n_pass++;
        n_total++; if (bf_op[1] !== 24'h224470) $display("FAIL issue_s1_op1 got %h want 224470", bf_op[1]); else n_pass++;
        n_total++; if (bf_op[2] !== {p0, p1, 8'h70}) $display("FAIL issue_s2_op0 got %h want %h", bf_op[2], {p0, p1, 8'h70}); else n_pass++;
        n_total++; if (bf_op[3] !== {q0, q1, 8'h09}) $display("FAIL issue_s2_op1 got %h want %h", bf_op[3], {q0, q1, 8'h09}); else n_pass++;
        n_total++; if (bfz_bad != 0) $display("FAIL issue_idle_operands_zero got %0d want 0", bfz_bad); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== y[i]) $display("FAIL issue_out_X%0d got %h want %h", i, got[i], y[i]); else n_pass++;
        end
    endtask

    task automatic test_impulse;
        frame_t x;
        x = '{8'h70, 8'h00, 8'h00, 8'h00};
        do_frame(x, -1, 0, 0, 0);
        n_total++; if (first_ov != 7) $display("FAIL impulse_latency got %0d want 7", first_ov); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== 8'h70) $display("FAIL impulse_X%0d got %h want 70", i, got[i]); else n_pass++;
        end
    endtask

    task automatic test_random_frames;
        frame_t x, y;
        for (int f = 0; f < 6; f++) begin
            rand_frame(x);
            model(x, 4'd0, y);
            do_frame(x, -1, 0, 0, 0);
            n_total++; if (first_ov != 7 || ov_drop != 0) $display("FAIL random_latency got %0d/%0d want 7/0", first_ov, ov_drop); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++; if (got[i] !== y[i]) $display("FAIL random_f%0d_X%0d got %h want %h", f, i, got[i], y[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_stall;
        frame_t x, y;
        rand_frame(x);
        model(x, 4'd0, y);
        do_frame(x, 1, 5, 0, 0);
        n_total++; if (stall_seen != 5) $display("FAIL stall_cycles got %0d want 5", stall_seen); else n_pass++;
        n_total++; if (held !== y[1] || held_bad != 0) $display("FAIL stall_hold got %h/%0d want %h/0", held, held_bad, y[1]); else n_pass++;
        n_total++; if (ov_drop != 0) $display("FAIL stall_valid_drop got %0d want 0", ov_drop); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== y[i]) $display("FAIL stall_X%0d got %h want %h", i, got[i], y[i]); else n_pass++;
        end
    endtask

    task automatic test_dropped_writeback;
        frame_t x, y;
        for (int f = 0; f < 4; f++) begin
            rand_frame(x);
            drop_mask = 4'd1 << f;
            model(x, drop_mask, y);
            do_frame(x, -1, 0, 0, 0);
            n_total++; if (first_ov != 7) $display("FAIL drop_latency got %0d want 7", first_ov); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++; if (got[i] !== y[i]) $display("FAIL drop_op%0d_X%0d got %h want %h", f, i, got[i], y[i]); else n_pass++;
            end
        end
        drop_mask = 4'd0;
    endtask

    task automatic test_spurious_valid;
        frame_t x, y;
        rand_frame(x);
        model(x, 4'd0, y);
        do_frame(x, -1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== y[i]) $display("FAIL spurious_X%0d got %h want %h", i, got[i], y[i]); else n_pass++;
        end
    endtask

    task automatic test_hold_valid;
        frame_t x, y;
        rand_frame(x);
        model(x, 4'd0, y);
        do_frame(x, -1, 0, 1, 0);
        n_total++; if (accepts != 4) $display("FAIL hold_accepts got %0d want 4", accepts); else n_pass++;
        n_total++; if (inready_bad != 0) $display("FAIL hold_in_ready_low got %0d want 0", inready_bad); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== y[i]) $display("FAIL hold_X%0d got %h want %h", i, got[i], y[i]); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL hold_in_ready_after got %b want 1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe;
        frame_t x, y;
        rand_frame(x);
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1; bus.in_data = x[k];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (bus.bf_en !== 1'b1) $display("FAIL midreset_s2_i1_issue got %b want 1", bus.bf_en); else n_pass++;
        #1;
        rst_n = 1'b0;
        tb_frames = 0;
        #1;
        n_total++; if (bus.bf_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL midreset_outputs got %b%b%b want 000", bus.bf_en, bus.out_valid, bus.busy); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        force_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        force_valid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL midreset_load got %b%b want 10", bus.in_ready, bus.busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (dut.r_mem[i] !== 8'h00) $display("FAIL midreset_mem%0d got %h want 00", i, dut.r_mem[i]); else n_pass++;
        end
        @(posedge clk); #1;
        rand_frame(x);
        model(x, 4'd0, y);
        do_frame(x, -1, 0, 0, 0);
        n_total++; if (first_ov != 7) $display("FAIL midreset_latency got %0d want 7", first_ov); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== y[i]) $display("FAIL midreset_X%0d got %h want %h", i, got[i], y[i]); else n_pass++;
        end
    endtask

`ifdef FFT_FEEDER_FRAME_CNT_EN
    task automatic test_frame_cnt;
        frame_t x;
        logic [7:0] start;
        @(negedge clk);
        n_total++; if (bus.frame_cnt !== 8'(tb_frames)) $display("FAIL frame_cnt_now got %0d want %0d", bus.frame_cnt, 8'(tb_frames)); else n_pass++;
        start = 8'(tb_frames);
        @(posedge clk); #1;
        for (int f = 0; f < 256; f++) begin
            rand_frame(x);
            do_frame(x, -1, 0, 0, 0);
            if (f == 0) begin
                n_total++; if (bus.frame_cnt !== start + 8'd1) $display("FAIL frame_cnt_inc got %0d want %0d", bus.frame_cnt, start + 8'd1); else n_pass++;
            end
        end
        n_total++; if (bus.frame_cnt !== start) $display("FAIL frame_cnt_wrap got %0d want %0d", bus.frame_cnt, start); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_issue_order();
        test_impulse();
        test_random_frames();
        test_stall();
        test_dropped_writeback();
        test_spurious_valid();
        test_hold_valid();
        test_reset_midframe();
`ifdef FFT_FEEDER_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
